icache_refill: RTL and testbench

Miss-handling engine between `icache` and the instruction memory bus. On a cache miss it latches the missing address, issues one line-aligned read request, collects the line as a sequence of beats, and presents the assembled line, index and tag to `icache` as a single-cycle fill write. One miss is outstanding at a time. `busy` tells the fetch stage to hold its PC.

---
 rtl/constants_pkg.sv | 21 ++
 rtl/icache_refill.sv | 147 ++++++++++++++
 tb/tb_icache_refill.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/constants_pkg.sv
// Shared icache geometry and refill engine state encoding.
// Used by icache and icache_refill.
package constants_pkg;

   localparam int XLEN   = 32;
   localparam int ICLLEN = 128;
   localparam int ICLN   = 16;

   localparam int IC_OFFSET_BITS = $clog2(ICLLEN / 8);
   localparam int IC_INDEX_BITS  = $clog2(ICLN);
   localparam int IC_TAG_BITS    =
      XLEN - IC_INDEX_BITS - IC_OFFSET_BITS;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RECV,
      FILL
   } refill_state_t;

endpackage

// File: rtl/icache_refill.sv
// icache miss engine: one line read per miss, beats assembled, single fill write.
// Define ICACHE_REFILL_TIMEOUT_EN to enable the REQ/RECV watchdog and err pulse.
module icache_refill
   import constants_pkg::*;
#(
   parameter int BEAT_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     miss,
   input  logic [XLEN-1:0]          addr,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [XLEN-1:0]          mem_req_addr,
   input  logic                     mem_rsp_valid,
   input  logic [BEAT_W-1:0]        mem_rsp_data,
   output logic                     fill_valid,
   output logic [IC_INDEX_BITS-1:0] fill_index,
   output logic [IC_TAG_BITS-1:0]   fill_tag,
   output logic [ICLLEN-1:0]        fill_data,
   output logic                     busy,
   output logic                     err
);

   localparam int BEATS = ICLLEN / BEAT_W;
   localparam int CNT_W = $clog2(BEATS) + 1;

   localparam logic [XLEN-1:0] LINE_MASK =
      ~XLEN'((1 << IC_OFFSET_BITS) - 1);

   refill_state_t     state_q, state_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [ICLLEN-1:0] line_q, line_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic              req_q, req_d;
   logic              fill_q, fill_d;
   logic              busy_q, busy_d;

`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] to_q, to_d;
   logic            err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      line_d  = line_q;
      beat_d  = beat_q;
`ifdef ICACHE_REFILL_TIMEOUT_EN
      to_d  = to_q;
      err_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (enable && miss) begin
               addr_d  = addr & LINE_MASK;
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               beat_d  = '0;
               state_d = RECV;
            end
         end
         RECV: begin
            if (mem_rsp_valid) begin
               for (int k = 0; k < BEATS; k++) begin
                  if (beat_q == CNT_W'(k)) begin
                     line_d[k*BEAT_W +: BEAT_W] = mem_rsp_data;
                  end
               end
               beat_d = beat_q + CNT_W'(1);
               if (beat_q == CNT_W'(BEATS - 1)) begin
                  state_d = FILL;
               end
            end
         end
         FILL: state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef ICACHE_REFILL_TIMEOUT_EN
      // A handshake or last beat this cycle leaves the state, so it beats the watchdog.
      if (state_q == IDLE) begin
         to_d = '0;
      end else if (state_q == REQ || state_q == RECV) begin
         if (to_q != TO_W'(TIMEOUT_CYC)) begin
            to_d = to_q + TO_W'(1);
         end
         if (to_q >= TO_W'(TIMEOUT_CYC - 1) && state_d == state_q) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end
      end
`endif
      req_d  = (state_d == REQ);
      fill_d = (state_d == FILL);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         line_q  <= '0;
         beat_q  <= '0;
         req_q   <= 1'b0;
         fill_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
         to_q  <= '0;
         err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
         beat_q  <= beat_d;
         req_q   <= req_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
`ifdef ICACHE_REFILL_TIMEOUT_EN
         to_q  <= to_d;
         err_q <= err_d;
`endif
      end
   end

   assign mem_req_valid = req_q;
   assign mem_req_addr  = addr_q;
   assign fill_valid    = fill_q;
   assign fill_index    = addr_q[IC_OFFSET_BITS +: IC_INDEX_BITS];
   assign fill_tag      = addr_q[XLEN-1 -: IC_TAG_BITS];
   assign fill_data     = line_q;
   assign busy          = busy_q;

`ifdef ICACHE_REFILL_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Randomized and directed bench for icache_refill against a transaction-level model.
// Geometry: XLEN=32, ICLLEN=128, ICLN=16, BEAT_W=32.
module tb_icache_refill;

   localparam int TO = 24;
`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic         miss = 1'b0;
   logic [31:0]  addr = '0;
   logic         mem_req_valid;
   logic         mem_req_ready = 1'b0;
   logic [31:0]  mem_req_addr;
   logic         mem_rsp_valid = 1'b0;
   logic [31:0]  mem_rsp_data = '0;
   logic         fill_valid;
   logic [3:0]   fill_index;
   logic [23:0]  fill_tag;
   logic [127:0] fill_data;
   logic         busy;
   logic         err;

   icache_refill #(.BEAT_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .miss(miss),
      .addr(addr),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data),
      .fill_valid(fill_valid),
      .fill_index(fill_index),
      .fill_tag(fill_tag),
      .fill_data(fill_data),
      .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit run = 1'b0;

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Transaction-level model: one outstanding miss, beats land by arrival order.
   bit           m_busy, m_req, m_fill, m_err;
   logic [31:0]  m_addr;
   logic [127:0] m_line;
   int           m_beats, m_cyc;

   always @(posedge clk) begin
      bit leave;
      if (rst) begin
         m_busy = 0; m_req = 0; m_fill = 0; m_err = 0;
         m_addr = '0; m_line = '0; m_beats = 0; m_cyc = 0;
      end else begin
         m_err = 0;
         if (m_fill) begin
            m_fill = 0;
            m_busy = 0;
         end else if (!m_busy) begin
            if (enable && miss) begin
               m_busy = 1; m_req = 1; m_addr = addr; m_cyc = 0;
            end
         end else begin
            leave = m_req ? mem_req_ready
                          : (mem_rsp_valid && m_beats == 3);
            m_cyc++;
            if (TO_EN && m_cyc >= TO && !leave) begin
               m_busy = 0; m_req = 0; m_err = 1;
            end else if (m_req) begin
               if (mem_req_ready) begin
                  m_req = 0;
                  m_beats = 0;
               end
            end else if (mem_rsp_valid) begin
               m_line[m_beats*32 +: 32] = mem_rsp_data;
               m_beats++;
               if (m_beats == 4) m_fill = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         check("busy", busy, m_busy);
         check("req_valid", mem_req_valid, m_req);
         check("fill_valid", fill_valid, m_fill);
         check("err", err, m_err);
         if (m_req) check("req_addr", mem_req_addr, {m_addr[31:4], 4'h0});
         if (m_fill) begin
            check("fill_index", fill_index, m_addr[7:4]);
            check("fill_tag", fill_tag, m_addr[31:8]);
            check("fill_data", fill_data, m_line);
         end
      end
   end

   task automatic refill(input logic [31:0] a, input logic [31:0] ereq,
                         input logic [3:0] eidx, input logic [23:0] etag,
                         input int rdly, input int gap, input bit noise,
                         input logic [127:0] line);
      enable = 1'b1;
      if (noise) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data = 32'hBAD0_0001;
         tick();
      end
      mem_rsp_valid = 1'b0;
      miss = 1'b1;
      addr = a;
      tick();
      miss = noise;
      addr = noise ? 32'h5555_5550 : $urandom;
      for (int i = 0; i < rdly; i++) begin
         mem_rsp_valid = noise;
         mem_rsp_data = $urandom;
         check("req_hold", mem_req_valid, 1'b1);
         check("req_addr_lit", mem_req_addr, ereq);
         tick();
      end
      check("req_addr_lit", mem_req_addr, ereq);
      mem_req_ready = 1'b1;
      mem_rsp_valid = noise;
      tick();
      mem_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_rsp_valid = 1'b0;
         for (int g = 0; g < gap; g++) tick();
         mem_rsp_valid = 1'b1;
         mem_rsp_data = line[k*32 +: 32];
         tick();
      end
      mem_rsp_valid = 1'b0;
      check("fill_lit", fill_valid, 1'b1);
      check("index_lit", fill_index, eidx);
      check("tag_lit", fill_tag, etag);
      check("data_lit", fill_data, line);
      tick();
      miss = 1'b0;
      check("busy_after", busy, 1'b0);
      check("fill_after", fill_valid, 1'b0);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_busy", busy, 1'b0);
      check("rst_req", mem_req_valid, 1'b0);
      check("rst_fill", fill_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_addr", mem_req_addr, 32'h0);
      check("rst_index", fill_index, 4'h0);
      check("rst_tag", fill_tag, 24'h0);
      check("rst_data", fill_data, 128'h0);
      rst = 1'b0;
      run = 1'b1;

      refill(32'h0000_1234, 32'h0000_1230, 4'h3, 24'h000012, 0, 0, 0,
             128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
      refill(32'hDEAD_BEEF, 32'hDEAD_BEE0, 4'hE, 24'hDEADBE, 5, 2, 0,
             128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0);
      refill(32'h0000_ABC8, 32'h0000_ABC0, 4'hC, 24'h0000AB, 2, 2, 1,
             128'h44444444_33333333_22222222_11111111);

      enable = 1'b1;
      miss = 1'b1;
      addr = 32'h0000_2468;
      tick();
      miss = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data = $urandom;
         tick();
      end
      mem_rsp_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_fill", fill_valid, 1'b0);
      check("abort_req", mem_req_valid, 1'b0);
      refill(32'h0001_0F00, 32'h0001_0F00, 4'h0, 24'h00010F, 1, 0, 0,
             128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);

      miss = 1'b1;
      addr = 32'h0000_4440;
      tick();
      miss = 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
      for (int i = 0; i < TO; i++) begin
         check("to_wait_err", err, 1'b0);
         check("to_wait_busy", busy, 1'b1);
         tick();
      end
      check("to_err", err, 1'b1);
      check("to_busy", busy, 1'b0);
      check("to_fill", fill_valid, 1'b0);
      tick();
      check("to_err_once", err, 1'b0);
`else
      for (int i = 0; i < TO + 8; i++) begin
         check("noto_err", err, 1'b0);
         check("noto_req", mem_req_valid, 1'b1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
`endif

      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(99) == 0);
         enable = ($urandom_range(3) != 0);
         miss = ($urandom_range(2) == 0);
         addr = $urandom;
         mem_req_ready = ($urandom_range(4) < 2);
         mem_rsp_valid = $urandom_range(1) == 1;
         mem_rsp_data = $urandom;
         tick();
      end
      rst = 1'b0;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
